// File: rtl/ysyx_220066_muldiv_iter.sv
// Iterative RV64M multiply/divide unit for the EX stage.
// Multiplies retire MUL_STEP multiplier bits per cycle (shift-add on magnitudes);
// divides use restoring division, one quotient bit per cycle. Divide-by-zero,
// signed overflow and illegal W-form multiplies bypass the iteration entirely.
module ysyx_220066_muldiv_iter #(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [2:0]      funct3,
    input  logic            is_w,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            error,
    output logic            busy
);

    // W-form operand width (32 bits for RV64).
    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN + 1);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          op_q;
    logic                is_w_q;
    logic                neg_q;      // product / quotient needs negation
    logic                rneg_q;     // remainder needs negation
    logic [2*XLEN-1:0]   acc_q;      // running product
    logic [2*XLEN-1:0]   mcand_q;    // multiplicand, shifted left each step
    logic [XLEN-1:0]     mplier_q;   // multiplier (mul) or dividend/quotient (div)
    logic [XLEN-1:0]     rem_q;      // partial remainder
    logic [XLEN-1:0]     dvsr_q;     // divisor magnitude
    logic                out_valid_q;
    logic [XLEN-1:0]     result_q;
    logic                error_q;

    // Sign-extend the low half when the operation is a W form.
    function automatic logic [XLEN-1:0] fit_w(input logic w, input logic [XLEN-1:0] v);
        fit_w = w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    logic                in_mul, sext_in, a_signed, b_signed, a_neg, b_neg;
    logic                in_illegal, div_zero, div_ovf;
    logic [XLEN-1:0]     a_ext, b_ext, a_mag, b_mag, min_neg, spec_res;
    logic [CW-1:0]       n_init;

    // Request decode: operand extension, magnitudes, special cases, iteration count.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        in_mul   = !funct3[2];
        sext_in  = !in_mul && !funct3[0];
        a_ext    = src1;
        b_ext    = src2;
        if (is_w) begin
            a_ext = sext_in ? {{HALF{src1[HALF-1]}}, src1[HALF-1:0]} : {{HALF{1'b0}}, src1[HALF-1:0]};
            b_ext = sext_in ? {{HALF{src2[HALF-1]}}, src2[HALF-1:0]} : {{HALF{1'b0}}, src2[HALF-1:0]};
        end
        a_signed = in_mul ? (funct3 == F_MULH || funct3 == F_MULHSU) : !funct3[0];
        b_signed = in_mul ? (funct3 == F_MULH) : !funct3[0];
        a_neg    = a_signed && a_ext[XLEN-1];
        b_neg    = b_signed && b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;

        in_illegal = is_w && in_mul && (funct3 != F_MUL);
        min_neg    = is_w ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero   = !in_mul && (b_ext == '0);
        div_ovf    = sext_in && (a_ext == min_neg) && (b_ext == '1);

        if (in_mul) n_init = is_w ? CW'(HALF / MUL_STEP) : CW'(XLEN / MUL_STEP);
        else        n_init = is_w ? CW'(HALF) : CW'(XLEN);

        spec_res = '0;
        if (div_zero)     spec_res = funct3[1] ? a_ext : '1;
        else if (div_ovf) spec_res = funct3[1] ? '0 : a_ext;
        spec_res = fit_w(is_w, spec_res);
    end

    logic [2*XLEN-1:0]   acc_d;
    logic [XLEN:0]       trial;
    logic                ge;
    logic [XLEN-1:0]     rem_d, quo_d;

    // One iteration: MUL_STEP shift-add terms, or one restoring-divide step.
    always_comb begin
        acc_d = acc_q;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier_q[j]) acc_d = acc_d + (mcand_q << j);
        end
        trial = {rem_q, mplier_q[XLEN-1]};
        ge    = trial >= {1'b0, dvsr_q};
        // The true difference is below the divisor, so the low XLEN bits are exact.
        rem_d = ge ? (trial[XLEN-1:0] - dvsr_q) : trial[XLEN-1:0];
        quo_d = {mplier_q[XLEN-2:0], ge};
    end

    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo_s, rem_s, raw, fin_res;

    // Sign fix-up and result selection once the iterations are complete.
    always_comb begin
        prod  = neg_q ? -acc_q : acc_q;
        quo_s = neg_q ? -mplier_q : mplier_q;
        rem_s = rneg_q ? -rem_q : rem_q;
        if (!op_q[2]) raw = (op_q == F_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else          raw = op_q[1] ? rem_s : quo_s;
        fin_res = fit_w(is_w_q, raw);
    end

    // Control FSM and datapath registers; rst beats flush, flush beats everything else.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            is_w_q      <= 1'b0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            error_q     <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= funct3;
                        is_w_q   <= is_w;
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        cnt_q    <= n_init;
                        acc_q    <= '0;
                        mcand_q  <= {{XLEN{1'b0}}, a_mag};
                        // Divides pre-align a W-form dividend so its MSB is shifted out first.
                        mplier_q <= in_mul ? b_mag : (is_w ? (a_mag << HALF) : a_mag);
                        rem_q    <= '0;
                        dvsr_q   <= b_mag;
                        error_q  <= 1'b0;
                        if (in_illegal) begin
                            state_q     <= DONE;
                            result_q    <= '0;
                            error_q     <= 1'b1;
                            out_valid_q <= 1'b1;
                        end else if (div_zero || div_ovf) begin
                            state_q     <= DONE;
                            result_q    <= spec_res;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        result_q    <= fin_res;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                        if (!op_q[2]) begin
                            acc_q    <= acc_d;
                            mcand_q  <= mcand_q << MUL_STEP;
                            mplier_q <= mplier_q >> MUL_STEP;
                        end else begin
                            rem_q    <= rem_d;
                            mplier_q <= quo_d;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign error     = error_q;

endmodule

// File: tb/tb_ysyx_220066_muldiv_iter.sv
// Scoreboard bench for ysyx_220066_muldiv_iter (XLEN=64, MUL_STEP=2).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares
// whenever out_valid rises. Latency is counted in clock edges after the accept edge.
module tb_ysyx_220066_muldiv_iter;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, is_w, flush, out_valid, out_ready, error, busy;
    logic [2:0]  funct3;
    logic [63:0] src1, src2, result;

    ysyx_220066_muldiv_iter #(.XLEN(64), .MUL_STEP(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .funct3(funct3), .is_w(is_w), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .error(error), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic        err;
        int          accept_cyc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: compare each newly presented result against the oldest expectation.
    logic seen_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            seen_valid = 1'b0;
        end else begin
            if (out_valid && !seen_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check({e.name, ".result"}, result, e.res);
                    check({e.name, ".error"}, {63'b0, error}, {63'b0, e.err});
                    check({e.name, ".latency"}, 64'(cyc - e.accept_cyc), 64'(e.lat));
                end
            end
            seen_valid = out_valid;
        end
    end

    // Present one request at a negedge; it is accepted at the following posedge.
    task automatic issue(input string name, input logic [2:0] f, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input bit push,
                         input logic [63:0] er, input logic ee, input int lat);
        int g = 0;
        while (!in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        check({name, ".in_ready"}, {63'b0, in_ready}, 64'd1);
        funct3   = f;
        is_w     = w;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) sb_q.push_back('{name, er, ee, cyc, lat});
        @(negedge clk);
    endtask

    // Wait for all expectations to be consumed; in_ready must stay low meanwhile.
    task automatic drain(input string name);
        int g      = 0;
        bit ir_bad = 1'b0;
        while ((sb_q.size() != 0 || !in_ready) && g < 300) begin
            if (sb_q.size() != 0 && in_ready) ir_bad = 1'b1;
            @(negedge clk);
            g++;
        end
        check({name, ".drained"}, 64'(sb_q.size()), 64'd0);
        check({name, ".in_ready_low"}, {63'b0, ir_bad}, 64'd0);
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] er, input logic ee, input int lat);
        issue(name, f, w, a, b, 1'b1, er, ee, lat);
        drain(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        bit stable_bad, rdy_bad, valid_seen;
        rst = 1'b1; in_valid = 1'b0; src1 = '0; src2 = '0; funct3 = '0;
        is_w = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset.out_valid", {63'b0, out_valid}, 64'd0);
        check("reset.result", result, 64'd0);
        check("reset.error", {63'b0, error}, 64'd0);
        check("reset.busy", {63'b0, busy}, 64'd0);
        check("reset.in_ready", {63'b0, in_ready}, 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Multiplies
        run_op("mul",    F_MUL,    1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 33);
        run_op("mulh",   F_MULH,   1'b0, '1, '1, 64'h0, 1'b0, 33);
        run_op("mulhu",  F_MULHU,  1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 33);
        run_op("mulhsu", F_MULHSU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 33);
        run_op("mulw",   F_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 17);

        // Divides
        run_op("div",  F_DIV, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65);
        run_op("rem",  F_REM, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65);
        run_op("divw", F_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33);

        // Divide-by-zero and signed overflow resolve on the accept edge
        run_op("divu_by0", F_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        run_op("rem_by0",  F_REM,  1'b0, 64'd5, 64'd0, 64'd5, 1'b0, 0);
        run_op("div_ovf",  F_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1'b0, 0);
        run_op("rem_ovf",  F_REM,  1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1'b0, 0);

        // Backpressure: result held while out_ready is low
        out_ready = 1'b0;
        issue("mul_bp", F_MUL, 1'b0, 64'd3, 64'd5, 1'b1, 64'd15, 1'b0, 33);
        g = 0;
        while (!out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("bp.out_valid", {63'b0, out_valid}, 64'd1);
        stable_bad = 1'b0;
        rdy_bad    = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (result !== 64'd15 || !out_valid) stable_bad = 1'b1;
            if (in_ready) rdy_bad = 1'b1;
        end
        check("bp.result_stable", {63'b0, stable_bad}, 64'd0);
        check("bp.in_ready_low", {63'b0, rdy_bad}, 64'd0);
        out_ready = 1'b1;
        drain("mul_bp");

        // Flush in the middle of a divide
        issue("div_flush", F_DIV, 1'b0, 64'd100, 64'd7, 1'b0, '0, 1'b0, 0);
        repeat (19) @(negedge clk);
        check("flush.busy_before", {63'b0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush.busy_after", {63'b0, busy}, 64'd0);
        check("flush.in_ready_after", {63'b0, in_ready}, 64'd1);
        valid_seen = 1'b0;
        repeat (80) begin
            if (out_valid) valid_seen = 1'b1;
            @(negedge clk);
        end
        check("flush.no_out_valid", {63'b0, valid_seen}, 64'd0);
        run_op("mul_after_flush", F_MUL, 1'b0, 64'd7, 64'd6, 64'd42, 1'b0, 33);

        // Reset in the middle of a divide
        issue("div_rst", F_DIV, 1'b0, 64'd1000, 64'd3, 1'b0, '0, 1'b0, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_mid.result", result, 64'd0);
        check("rst_mid.error", {63'b0, error}, 64'd0);
        check("rst_mid.busy", {63'b0, busy}, 64'd0);
        check("rst_mid.in_ready", {63'b0, in_ready}, 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Illegal W-form multiply-high, then a legal op clears the error flag
        run_op("mulh_w_illegal", F_MULH, 1'b1, 64'd5, 64'd3, 64'd0, 1'b1, 0);
        run_op("mulw_after_err", F_MUL,  1'b1, 64'd9, 64'd9, 64'd81, 1'b0, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
